// File: rtl/commit_monitor.sv
// Commit-stream monitor: run-state FSM, saturating perf counters, hang detection
// and a circular trace of the last DEPTH committed PCs readable by age index.
module commit_monitor #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [31:0]              i_pc_debug,
  input  logic                     i_insn_vld,
  input  logic                     i_halt,
  input  logic                     i_ctrl,
  input  logic                     i_mispred,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [31:0]              o_rd_pc,
  output logic                     o_rd_valid,
  output logic [31:0]              o_last_pc,
  output logic [CNT_W-1:0]         o_cycle_cnt,
  output logic [CNT_W-1:0]         o_instr_cnt,
  output logic [CNT_W-1:0]         o_ctrl_cnt,
  output logic [CNT_W-1:0]         o_mispred_cnt,
  output logic [1:0]               o_state,
  output logic                     o_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10, HUNG = 2'b11} state_e;

  state_e           state_q, state_d;
  logic             done_q;
  logic [IW-1:0]    idle_q, idle_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, instr_q, instr_d, ctrl_q, ctrl_d, mis_q, mis_d;
  logic [31:0]      last_pc_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      occ_q;
  logic [31:0]      mem_q [DEPTH];

  logic accepting, commit, cyc_inc;
  logic [AW-1:0] rd_ptr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && c != {CNT_W{1'b1}}) ? c + CNT_W'(1) : c;
  endfunction

  assign accepting = (state_q == IDLE) || (state_q == RUN);
  assign commit    = accepting && i_insn_vld;
  // IDLE cycles only count once the first commit arrives.
  assign cyc_inc   = (state_q == RUN) || ((state_q == IDLE) && commit);

  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    case (state_q)
      IDLE: begin
        if (i_halt)      state_d = HALTED;
        else if (commit) state_d = RUN;
      end
      RUN: begin
        idle_d = commit ? '0 : idle_q + IW'(1);
        if (i_halt) state_d = HALTED;
        else if (!commit && idle_q == IW'(TIMEOUT_CYCLES - 1)) state_d = HUNG;
      end
      default: state_d = state_q;
    endcase
    cyc_d   = sat_inc(cyc_q, cyc_inc);
    instr_d = sat_inc(instr_q, commit);
    ctrl_d  = sat_inc(ctrl_q, commit && i_ctrl);
    mis_d   = sat_inc(mis_q, commit && i_mispred);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      idle_q    <= '0;
      cyc_q     <= '0;
      instr_q   <= '0;
      ctrl_q    <= '0;
      mis_q     <= '0;
      last_pc_q <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= state_d[1];
      idle_q  <= idle_d;
      cyc_q   <= cyc_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
      mis_q   <= mis_d;
      if (commit) begin
        last_pc_q <= i_pc_debug;
        wr_ptr_q  <= wr_ptr_q + AW'(1);
        if (occ_q != (AW+1)'(DEPTH)) occ_q <= occ_q + (AW+1)'(1);
      end
    end
  end

  // Trace storage carries no reset; occupancy alone qualifies reads.
  always_ff @(posedge i_clk) begin
    if (commit && !i_reset) mem_q[wr_ptr_q] <= i_pc_debug;
  end

  assign rd_ptr        = wr_ptr_q - AW'(1) - i_rd_idx;
  assign o_rd_valid    = {1'b0, i_rd_idx} < occ_q;
  assign o_rd_pc       = o_rd_valid ? mem_q[rd_ptr] : 32'h0;
  assign o_last_pc     = last_pc_q;
  assign o_cycle_cnt   = cyc_q;
  assign o_instr_cnt   = instr_q;
  assign o_ctrl_cnt    = ctrl_q;
  assign o_mispred_cnt = mis_q;
  assign o_state       = state_q;
  assign o_done        = done_q;
endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: vector table plus hand sequences for
// trace wrap, timeout, halt-with-commit and mid-run reset.
module tb_commit_monitor;
  logic        clk = 1'b0;
  logic        rst, vld, halt, ctrl, mis;
  logic [31:0] pc;
  logic [2:0]  idx;
  logic [31:0] rd_pc, last_pc, cyc, instr, ctl, mp;
  logic        rd_valid, done;
  logic [1:0]  state;
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  commit_monitor #(.DEPTH(8), .TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_pc_debug(pc), .i_insn_vld(vld), .i_halt(halt),
    .i_ctrl(ctrl), .i_mispred(mis), .i_rd_idx(idx), .o_rd_pc(rd_pc), .o_rd_valid(rd_valid),
    .o_last_pc(last_pc), .o_cycle_cnt(cyc), .o_instr_cnt(instr), .o_ctrl_cnt(ctl),
    .o_mispred_cnt(mp), .o_state(state), .o_done(done));

  typedef struct {
    logic rst, vld, halt, ctrl, mis;
    logic [31:0] pc;
    logic [2:0] idx;
    bit chk;
    logic [1:0] st;
    logic dn;
    logic [31:0] instr, cyc, ctl, mp, last;
    logic rdv;
    logic [31:0] rdpc;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are observed 1ns after the rising edge.
  task automatic step(input logic r, v, h, c, m, input logic [31:0] p, input logic [2:0] i);
    @(negedge clk);
    rst = r; vld = v; halt = h; ctrl = c; mis = m; pc = p; idx = i;
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] p);
    step(0, 1, 0, 0, 0, p, 0);
  endtask

  task automatic rd(input logic [2:0] i);
    @(negedge clk);
    vld = 0; halt = 0; rst = 0; idx = i;
    #1;
  endtask

  initial begin
    rst = 1; vld = 0; halt = 0; ctrl = 0; mis = 0; pc = 0; idx = 0;
    // rst vld halt ctrl mis pc idx | chk st done instr cyc ctl mp last rdv rdpc
    tbl.push_back('{1,0,0,0,0,32'h0,0, 1,2'b00,0,0,0,0,0,32'h0,0,32'h0});
    tbl.push_back('{0,1,0,0,0,32'h0,0, 1,2'b01,0,1,1,0,0,32'h0,1,32'h0});
    tbl.push_back('{0,1,0,0,0,32'h4,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,32'h8,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,32'hC,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,1,0,0,32'h10,0, 1,2'b10,1,5,5,0,0,32'h10,1,32'h10});
    tbl.push_back('{0,0,0,0,0,32'h0,4, 1,2'b10,1,5,5,0,0,32'h10,1,32'h0});
    tbl.push_back('{0,0,0,0,0,32'h0,5, 1,2'b10,1,5,5,0,0,32'h10,0,32'h0});
    tbl.push_back('{0,1,0,1,1,32'h80,0, 1,2'b10,1,5,5,0,0,32'h10,1,32'h10});
    // ctrl / mispredict counting, including a mispred flag without valid
    tbl.push_back('{1,0,0,0,0,32'h0,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,1,0,32'h200,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,32'h204,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,0,0,1,1,32'h0,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,1,1,32'h208,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,32'h20C,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,1,0,32'h210,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,32'h214,1, 1,2'b01,0,6,7,3,1,32'h214,1,32'h210});
    // mid-run reset beats a simultaneous commit
    tbl.push_back('{1,0,0,0,0,32'h0,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,1,0,32'h300,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,0,1,32'h304,0, 0,0,0,0,0,0,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,32'h308,0, 1,2'b01,0,3,3,1,1,32'h308,1,32'h308});
    tbl.push_back('{1,1,0,1,1,32'h999,0, 1,2'b00,0,0,0,0,0,32'h0,0,32'h0});
    tbl.push_back('{0,1,0,0,0,32'h30C,0, 1,2'b01,0,1,1,0,0,32'h30C,1,32'h30C});
    tbl.push_back('{0,0,0,0,0,32'h0,1, 1,2'b01,0,1,2,0,0,32'h30C,0,32'h0});

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].vld, tbl[k].halt, tbl[k].ctrl, tbl[k].mis, tbl[k].pc, tbl[k].idx);
      if (tbl[k].chk) begin
        chk($sformatf("v%0d.state", k), {30'h0, state}, {30'h0, tbl[k].st});
        chk($sformatf("v%0d.done", k), {31'h0, done}, {31'h0, tbl[k].dn});
        chk($sformatf("v%0d.instr", k), instr, tbl[k].instr);
        chk($sformatf("v%0d.cycle", k), cyc, tbl[k].cyc);
        chk($sformatf("v%0d.ctrl", k), ctl, tbl[k].ctl);
        chk($sformatf("v%0d.mispred", k), mp, tbl[k].mp);
        chk($sformatf("v%0d.last_pc", k), last_pc, tbl[k].last);
        chk($sformatf("v%0d.rd_valid", k), {31'h0, rd_valid}, {31'h0, tbl[k].rdv});
        chk($sformatf("v%0d.rd_pc", k), rd_pc, tbl[k].rdpc);
      end
    end

    // Occupancy after the mid-run reset held only one entry.
    for (int i = 1; i < 8; i++) begin
      rd(3'(i));
      chk($sformatf("rst.rdv%0d", i), {31'h0, rd_valid}, 32'h0);
    end

    // Trace wrap: 10 commits into 8 entries.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) commit(32'h100 + 32'(4 * i));
    chk("wrap.instr", instr, 32'd10);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      chk($sformatf("wrap.rdv%0d", i), {31'h0, rd_valid}, 32'h1);
      chk($sformatf("wrap.pc%0d", i), rd_pc, 32'h124 - 32'(4 * i));
    end

    // Timeout: one commit then 16 empty cycles.
    step(1, 0, 0, 0, 0, 0, 0);
    commit(32'h500);
    for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("hang.pre_state", {30'h0, state}, 32'h1);
    chk("hang.pre_done", {31'h0, done}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hang.state", {30'h0, state}, 32'h3);
    chk("hang.done", {31'h0, done}, 32'h1);
    chk("hang.cycle", cyc, 32'd17);
    commit(32'h504);
    chk("hang.instr", instr, 32'd1);
    chk("hang.cycle_frozen", cyc, 32'd17);
    chk("hang.last_pc", last_pc, 32'h500);

    // Halt together with a commit: that commit counts, later ones do not.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 32'h40, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 32'h44 + 32'(4 * i), 0);
    chk("hc.state", {30'h0, state}, 32'h2);
    chk("hc.instr", instr, 32'd1);
    chk("hc.cycle", cyc, 32'd1);
    chk("hc.ctrl", ctl, 32'd1);
    chk("hc.mispred", mp, 32'd0);
    chk("hc.last_pc", last_pc, 32'h40);
    chk("hc.idx0", rd_pc, 32'h40);
    rd(1);
    chk("hc.rdv1", {31'h0, rd_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
Downstream consumer of the pipelined core's commit/debug outputs (o_pc_debug, o_insn_vld, o_halt, o_ctrl, o_mispred). It tracks run state, counts cycles and instructions, and detects halt or hang. It keeps a circular trace of the last DEPTH committed PCs, readable by index. Used by benches and the on-board debug path to decide end of test and report performance.

Parameters:
DEPTH, 8, trace buffer entries; power of 2, >= 2
TIMEOUT_CYCLES, 1024, consecutive commit-free cycles in RUN before HUNG; >= 2
CNT_W, 32, width of every performance counter

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_pc_debug  in  32  PC of the committing instruction
i_insn_vld  in  1  commit valid this cycle
i_halt  in  1  core halt indication
i_ctrl  in  1  committing instruction is control-flow; qualified by i_insn_vld
i_mispred  in  1  committing instruction was mispredicted; qualified by i_insn_vld
i_rd_idx  in  $clog2(DEPTH)  trace read index; 0 = most recent commit
o_rd_pc  out  32  trace entry at i_rd_idx
o_rd_valid  out  1  i_rd_idx < occupancy
o_last_pc  out  32  PC of most recent counted commit
o_cycle_cnt  out  CNT_W  active cycles
o_instr_cnt  out  CNT_W  counted commits
o_ctrl_cnt  out  CNT_W  counted control-flow commits
o_mispred_cnt  out  CNT_W  counted mispredicts
o_state  out  2  00 IDLE, 01 RUN, 10 HALTED, 11 HUNG
o_done  out  1  state is HALTED or HUNG

Behaviour:
- Reset, applied at the clock edge while i_reset=1:
  - state goes to IDLE; all counters 0; o_last_pc 0.
  - trace occupancy 0 and write pointer 0; buffer contents need not be cleared.
  - idle counter 0.
  - Reset has priority over every other event, including mid-run.
- "Accepting" means state is IDLE or RUN. A "commit" means accepting and i_insn_vld=1.
- State transitions, evaluated each clock edge:
  - IDLE: i_halt -> HALTED; else commit -> RUN; else stay.
  - RUN: i_halt -> HALTED. Else, if there is no commit and the idle counter equals TIMEOUT_CYCLES-1 -> HUNG. Else stay.
  - HALTED and HUNG are sticky until reset. All inputs are ignored and all counters and the trace are frozen.
  - Halt beats timeout in the same cycle.
- Idle counter (RUN only):
  - Cleared on a commit; incremented on a commit-free cycle.
  - Result: HUNG is entered at the end of the TIMEOUT_CYCLES-th consecutive commit-free cycle.
- Counters are registered and saturate at all-ones (no wrap). Updated at the edge ending the qualifying cycle:
  - o_cycle_cnt: +1 every cycle in RUN, plus +1 in an IDLE cycle that has a commit.
  - o_instr_cnt: +1 per commit.
  - o_ctrl_cnt: +1 per commit with i_ctrl=1.
  - o_mispred_cnt: +1 per commit with i_mispred=1. i_ctrl/i_mispred with i_insn_vld=0 are ignored.
- Halt with a simultaneous commit: that commit is counted and traced, and its cycle is counted. Nothing is counted after that.
- Trace buffer:
  - Each commit writes i_pc_debug at the write pointer, then the pointer advances modulo DEPTH.
  - Occupancy increments and saturates at DEPTH; on wrap the oldest entry is overwritten.
  - o_last_pc is loaded on every commit.
- Read port, combinational from registered state:
  - Entry returned is (wr_ptr-1-i_rd_idx) mod DEPTH.
  - o_rd_valid = (i_rd_idx < occupancy).
  - o_rd_pc = 0 when o_rd_valid=0.
  - A commit becomes visible at idx 0 the cycle after it is presented.
- o_state and o_done are registered. o_done=1 from the cycle after the halt/timeout edge.

Test Plan:
1. Reset, then commits PCs 0x0,0x4,0x8,0xC,0x10 back-to-back, then i_halt -> instr_cnt=5, cycle_cnt=5, last_pc=0x10, state=10, done=1; idx0=0x10, idx4=0x0, idx5 rd_valid=0 and rd_pc=0.
2. DEPTH=8: 10 commits PCs 0x100..0x124 step 4 -> idx0=0x124, idx7=0x108, all idx valid, instr_cnt=10.
3. TIMEOUT_CYCLES=16: one commit then silence -> state=11 at the edge ending the 16th empty cycle, cycle_cnt frozen at 17. A later commit leaves instr_cnt=1.
4. 6 commits with i_ctrl on 3 and i_mispred on 1, plus i_mispred=1 with i_insn_vld=0 -> ctrl_cnt=3, mispred_cnt=1.
5. Commit (PC 0x40) with i_halt in the same cycle, then 3 more commits -> instr_cnt includes 0x40 only, last_pc=0x40, counters frozen.
6. After 3 commits in RUN, one-cycle i_reset=1 -> next cycle state=00, all counters 0, last_pc=0, rd_valid=0 for every idx. A subsequent commit restarts at instr_cnt=1.
